round_sequencer: RTL and testbench

- Game-round initiator for the symbol counter.
- Starts symbol generation, then issues the answer-period request (answerSig) and waits for the answer-period block to return postSig.
- Then compares the user's count against the true symbol count and shows the correct count and the win/lose result on four seven-segment digits.
- Sits between the top-level button logic, the symbol generator and the answer-period block.

---
 rtl/round_sequencer_pkg.sv | 34 +++
 rtl/round_sequencer_bin_to_seg2.sv | 28 ++
 rtl/round_sequencer.sv | 232 +++++++++++++++++++++++
 tb/tb_round_sequencer.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/round_sequencer_pkg.sv
// Shared types and seven-segment encoding for the round sequencer.
// Optional win-score display is enabled with the SCORE_TRACK_EN macro in round_sequencer.sv.
package round_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GEN    = 2'd1,
        ANSWER = 2'd2,
        RESULT = 2'd3
    } state_e;

    localparam logic [7:0] SEG_BLANK   = 8'hFF;
    localparam logic [7:0] DISPLAY_MAX = 8'd99;

    // Active-low segment code for one decimal digit; anything outside 0..9 is blank.
    function automatic logic [7:0] digit_to_seg(input logic [3:0] digit);
        logic [7:0] seg;
        case (digit)
            4'd0:    seg = 8'hC0;
            4'd1:    seg = 8'hF9;
            4'd2:    seg = 8'hA4;
            4'd3:    seg = 8'hB0;
            4'd4:    seg = 8'h99;
            4'd5:    seg = 8'h92;
            4'd6:    seg = 8'h82;
            4'd7:    seg = 8'hD8;
            4'd8:    seg = 8'h80;
            4'd9:    seg = 8'h90;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/round_sequencer_bin_to_seg2.sv
// Two-digit decimal display encoder: 8-bit binary in, saturated to 99,
// tens and ones digits out as active-low seven-segment codes.
module bin_to_seg2
    import round_sequencer_pkg::*;
(
    input  logic [7:0] bin,
    output logic [7:0] seg_tens,
    output logic [7:0] seg_ones
);

    logic [7:0] sat_s;
    logic [3:0] tens_s;
    logic [3:0] ones_s;

    // Clamp to the largest two-digit value, then split into decimal digits.
    always_comb begin
        if (bin > DISPLAY_MAX) begin
            sat_s = DISPLAY_MAX;
        end else begin
            sat_s = bin;
        end
        tens_s   = 4'(sat_s / 8'd10);
        ones_s   = 4'(sat_s % 8'd10);
        seg_tens = digit_to_seg(tens_s);
        seg_ones = digit_to_seg(ones_s);
    end

endmodule

// File: rtl/round_sequencer.sv
// Game-round sequencer: start -> symbol generation -> answer period -> result display.
// Define SCORE_TRACK_EN to keep a saturating win count shown on digits 2/3 while idle.
module round_sequencer
    import round_sequencer_pkg::*;
#(
    parameter int GEN_TIMEOUT_S = 15,
    parameter int ANS_TIMEOUT_S = 8,
    parameter int RESULT_HOLD_S = 4
) (
    input  logic       Clk100M,
    input  logic       Reset,
    input  logic       tick1Hz,
    input  logic       startBtn,
    input  logic       genDone,
    input  logic [7:0] symCount,
    input  logic       postSig,
    input  logic [7:0] userCount,
    output logic       genStart,
    output logic       answerSig,
    output logic       roundWin,
    output logic       fault,
    output logic [7:0] resultSeg0,
    output logic [7:0] resultSeg1,
    output logic [7:0] resultSeg2,
    output logic [7:0] resultSeg3
);

    localparam logic [4:0] GEN_LIMIT  = 5'(GEN_TIMEOUT_S);
    localparam logic [4:0] ANS_LIMIT  = 5'(ANS_TIMEOUT_S);
    localparam logic [4:0] HOLD_LIMIT = 5'(RESULT_HOLD_S);

    state_e     state_q, state_d;
    logic       btn_prev_q, btn_prev_d;
    logic       start_pulse_q, start_pulse_d;
    logic       gen_start_q, gen_start_d;
    logic       answer_sig_q, answer_sig_d;
    logic       round_win_q, round_win_d;
    logic       fault_q, fault_d;
    logic [4:0] sec_q, sec_d;
    logic [7:0] sym_q, sym_d;
    logic [7:0] user_q, user_d;
    logic [7:0] seg0_q, seg0_d;
    logic [7:0] seg1_q, seg1_d;
    logic [7:0] seg2_q, seg2_d;
    logic [7:0] seg3_q, seg3_d;

    logic [4:0] sec_inc_s;
    logic       start_accept_s;
    logic       gen_exit_s;
    logic       ans_post_s;
    logic       ans_timeout_s;
    logic       enter_result_s;
    logic       result_exit_s;
    logic       user_match_s;
    logic [7:0] user_next_s;
    logic [7:0] user_cnv_s;
    logic [7:0] sym_tens_s, sym_ones_s;
    logic [7:0] user_tens_s, user_ones_s;

    assign sec_inc_s      = sec_q + 5'd1;
    assign start_accept_s = (state_q == IDLE) && start_pulse_q;
    // genDone takes priority over the final GEN tick; both just latch symCount.
    assign gen_exit_s     = (state_q == GEN) && (genDone || (tick1Hz && (sec_inc_s == GEN_LIMIT)));
    assign ans_post_s     = (state_q == ANSWER) && postSig;
    assign ans_timeout_s  = (state_q == ANSWER) && !postSig && tick1Hz && (sec_inc_s == ANS_LIMIT);
    assign enter_result_s = ans_post_s || ans_timeout_s;
    assign result_exit_s  = (state_q == RESULT) && tick1Hz && (sec_inc_s == HOLD_LIMIT);
    assign user_next_s    = ans_post_s ? userCount : 8'd0;
    assign user_match_s   = (user_next_s == sym_q);

`ifdef SCORE_TRACK_EN
    logic [7:0] win_q, win_d;

    // Win tally: bumps on each winning RESULT entry, saturates at the display limit.
    always_comb begin
        if (enter_result_s && user_match_s && (win_q < DISPLAY_MAX)) begin
            win_d = win_q + 8'd1;
        end else begin
            win_d = win_q;
        end
    end

    // Win tally register; only a full reset clears it.
    always_ff @(posedge Clk100M) begin
        if (Reset) begin
            win_q <= 8'd0;
        end else begin
            win_q <= win_d;
        end
    end

    assign user_cnv_s = (state_q == RESULT) ? win_q : user_next_s;
`else
    assign user_cnv_s = (state_q == RESULT) ? user_q : user_next_s;
`endif

    bin_to_seg2 u_sym_seg (
        .bin      (sym_q),
        .seg_tens (sym_tens_s),
        .seg_ones (sym_ones_s)
    );

    bin_to_seg2 u_user_seg (
        .bin      (user_cnv_s),
        .seg_tens (user_tens_s),
        .seg_ones (user_ones_s)
    );

    // Round FSM next-state, pulse generation, count latching and display loading.
    always_comb begin
        state_d       = state_q;
        btn_prev_d    = startBtn;
        start_pulse_d = startBtn & ~btn_prev_q;
        gen_start_d   = 1'b0;
        answer_sig_d  = 1'b0;
        round_win_d   = round_win_q;
        fault_d       = fault_q;
        sym_d         = sym_q;
        user_d        = user_q;
        seg0_d        = seg0_q;
        seg1_d        = seg1_q;
        seg2_d        = seg2_q;
        seg3_d        = seg3_q;
        if (tick1Hz && (state_q != IDLE)) begin
            sec_d = sec_inc_s;
        end else begin
            sec_d = sec_q;
        end

        case (state_q)
            IDLE: begin
                if (start_accept_s) begin
                    state_d     = GEN;
                    gen_start_d = 1'b1;
                    fault_d     = 1'b0;
                    sec_d       = 5'd0;
                    seg0_d      = SEG_BLANK;
                    seg1_d      = SEG_BLANK;
                    seg2_d      = SEG_BLANK;
                    seg3_d      = SEG_BLANK;
                end else begin
                    state_d = IDLE;
                end
            end
            GEN: begin
                if (gen_exit_s) begin
                    state_d      = ANSWER;
                    answer_sig_d = 1'b1;
                    sec_d        = 5'd0;
                    sym_d        = symCount;
                end else begin
                    state_d = GEN;
                end
            end
            ANSWER: begin
                // postSig on the timeout tick still counts as a valid answer.
                if (enter_result_s) begin
                    state_d     = RESULT;
                    sec_d       = 5'd0;
                    user_d      = user_next_s;
                    fault_d     = ans_timeout_s;
                    round_win_d = user_match_s;
                    seg0_d      = sym_tens_s;
                    seg1_d      = sym_ones_s;
                    seg2_d      = user_tens_s;
                    seg3_d      = user_ones_s;
                end else begin
                    state_d = ANSWER;
                end
            end
            RESULT: begin
                if (result_exit_s) begin
                    state_d     = IDLE;
                    sec_d       = 5'd0;
                    round_win_d = 1'b0;
                    seg2_d      = user_tens_s;
                    seg3_d      = user_ones_s;
                end else begin
                    state_d = RESULT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge Clk100M) begin
        if (Reset) begin
            state_q       <= IDLE;
            btn_prev_q    <= 1'b0;
            start_pulse_q <= 1'b0;
            gen_start_q   <= 1'b0;
            answer_sig_q  <= 1'b0;
            round_win_q   <= 1'b0;
            fault_q       <= 1'b0;
            sec_q         <= 5'd0;
            sym_q         <= 8'd0;
            user_q        <= 8'd0;
            seg0_q        <= SEG_BLANK;
            seg1_q        <= SEG_BLANK;
            seg2_q        <= SEG_BLANK;
            seg3_q        <= SEG_BLANK;
        end else begin
            state_q       <= state_d;
            btn_prev_q    <= btn_prev_d;
            start_pulse_q <= start_pulse_d;
            gen_start_q   <= gen_start_d;
            answer_sig_q  <= answer_sig_d;
            round_win_q   <= round_win_d;
            fault_q       <= fault_d;
            sec_q         <= sec_d;
            sym_q         <= sym_d;
            user_q        <= user_d;
            seg0_q        <= seg0_d;
            seg1_q        <= seg1_d;
            seg2_q        <= seg2_d;
            seg3_q        <= seg3_d;
        end
    end

    assign genStart   = gen_start_q;
    assign answerSig  = answer_sig_q;
    assign roundWin   = round_win_q;
    assign fault      = fault_q;
    assign resultSeg0 = seg0_q;
    assign resultSeg1 = seg1_q;
    assign resultSeg2 = seg2_q;
    assign resultSeg3 = seg3_q;

endmodule

// File: tb/tb_round_sequencer.sv
// Directed self-checking bench for round_sequencer (default build, default parameters).
module tb_round_sequencer;

    logic       clk = 1'b0;
    logic       Reset;
    logic       tick1Hz;
    logic       startBtn;
    logic       genDone;
    logic [7:0] symCount;
    logic       postSig;
    logic [7:0] userCount;
    logic       genStart;
    logic       answerSig;
    logic       roundWin;
    logic       fault;
    logic [7:0] resultSeg0, resultSeg1, resultSeg2, resultSeg3;

    int tests_run  = 0;
    int tests_fail = 0;
    int gen_cnt    = 0;
    int ans_cnt    = 0;
    int both_cnt   = 0;
    int gen_base;
    int ans_base;

    always #5 clk = ~clk;

    round_sequencer dut (
        .Clk100M    (clk),
        .Reset      (Reset),
        .tick1Hz    (tick1Hz),
        .startBtn   (startBtn),
        .genDone    (genDone),
        .symCount   (symCount),
        .postSig    (postSig),
        .userCount  (userCount),
        .genStart   (genStart),
        .answerSig  (answerSig),
        .roundWin   (roundWin),
        .fault      (fault),
        .resultSeg0 (resultSeg0),
        .resultSeg1 (resultSeg1),
        .resultSeg2 (resultSeg2),
        .resultSeg3 (resultSeg3)
    );

    // Pulse monitor sampled on the falling edge.
    always @(negedge clk) begin
        if (genStart) gen_cnt++;
        if (answerSig) ans_cnt++;
        if (genStart && answerSig) both_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) tick1Hz = 1'b1;
            @(negedge clk) tick1Hz = 1'b0;
        end
    endtask

    task automatic start_round(input string tag);
        logic seen;
        seen = 1'b0;
        @(negedge clk) startBtn = 1'b1;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (genStart) seen = 1'b1;
        end
        startBtn = 1'b0;
        check_eq(tag, {31'd0, seen}, 32'd1);
    endtask

    task automatic gen_done(input logic [7:0] val);
        @(negedge clk) begin genDone = 1'b1; symCount = val; end
        @(negedge clk) genDone = 1'b0;
    endtask

    task automatic post(input logic [7:0] val);
        @(negedge clk) begin postSig = 1'b1; userCount = val; end
        @(negedge clk) postSig = 1'b0;
    endtask

    initial begin
        Reset = 1'b1; tick1Hz = 1'b0; startBtn = 1'b0; genDone = 1'b0;
        symCount = 8'd0; postSig = 1'b0; userCount = 8'd0;
        step(3);
        Reset = 1'b0;
        step(1);
        check_eq("rst_genStart", {31'd0, genStart}, 32'd0);
        check_eq("rst_answerSig", {31'd0, answerSig}, 32'd0);
        check_eq("rst_roundWin", {31'd0, roundWin}, 32'd0);
        check_eq("rst_fault", {31'd0, fault}, 32'd0);
        check_eq("rst_segs", {resultSeg0, resultSeg1, resultSeg2, resultSeg3}, 32'hFFFF_FFFF);

        // Normal winning round 12/12.
        start_round("win_start");
        tick(3);
        gen_done(8'd12);
        check_eq("win_answerSig", {31'd0, answerSig}, 32'd1);
        step(1);
        check_eq("win_answerSig_end", {31'd0, answerSig}, 32'd0);
        post(8'd12);
        check_eq("win_roundWin", {31'd0, roundWin}, 32'd1);
        check_eq("win_segs", {resultSeg0, resultSeg1, resultSeg2, resultSeg3}, 32'hF9A4_F9A4);
        tick(3);
        check_eq("win_hold3", {31'd0, roundWin}, 32'd1);
        tick(1);
        check_eq("win_idle4", {31'd0, roundWin}, 32'd0);
        check_eq("win_display_hold", {resultSeg0, resultSeg1, resultSeg2, resultSeg3}, 32'hF9A4_F9A4);
        check_eq("win_gen_cnt", gen_cnt, 32'd1);
        check_eq("win_ans_cnt", ans_cnt, 32'd1);

        // Losing round 7/9.
        start_round("loss_start");
        check_eq("loss_blank", {resultSeg0, resultSeg1, resultSeg2, resultSeg3}, 32'hFFFF_FFFF);
        gen_done(8'd7);
        post(8'd9);
        check_eq("loss_roundWin", {31'd0, roundWin}, 32'd0);
        check_eq("loss_segs", {resultSeg0, resultSeg1, resultSeg2, resultSeg3}, 32'hC0D8_C090);
        tick(4);

        // Answer timeout.
        start_round("to_start");
        gen_done(8'd5);
        tick(7);
        check_eq("to_fault_early", {31'd0, fault}, 32'd0);
        tick(1);
        check_eq("to_fault", {31'd0, fault}, 32'd1);
        check_eq("to_user_segs", {resultSeg2, resultSeg3}, 32'h0000_C0C0);
        check_eq("to_sym_segs", {resultSeg0, resultSeg1}, 32'h0000_C092);
        tick(4);
        check_eq("to_fault_sticky", {31'd0, fault}, 32'd1);
        start_round("to_restart");
        check_eq("to_fault_cleared", {31'd0, fault}, 32'd0);

        // postSig together with the final ANSWER tick.
        gen_done(8'd20);
        tick(7);
        @(negedge clk) begin tick1Hz = 1'b1; postSig = 1'b1; userCount = 8'd20; end
        @(negedge clk) begin tick1Hz = 1'b0; postSig = 1'b0; end
        check_eq("sim_fault", {31'd0, fault}, 32'd0);
        check_eq("sim_roundWin", {31'd0, roundWin}, 32'd1);
        check_eq("sim_user_segs", {resultSeg2, resultSeg3}, 32'h0000_A4C0);
        tick(4);

        // Saturation, and a start edge during GEN is ignored.
        gen_base = gen_cnt;
        start_round("sat_start");
        step(1);
        startBtn = 1'b1;
        step(3);
        startBtn = 1'b0;
        step(3);
        check_eq("sat_no_restart", gen_cnt - gen_base, 32'd1);
        gen_done(8'd150);
        post(8'd150);
        check_eq("sat_segs", {resultSeg0, resultSeg1, resultSeg2, resultSeg3}, 32'h9090_9090);
        check_eq("sat_roundWin", {31'd0, roundWin}, 32'd1);
        tick(4);

        // GEN timeout forces the answer phase and latches symCount.
        symCount = 8'd33;
        start_round("gto_start");
        tick(14);
        check_eq("gto_early", {31'd0, answerSig}, 32'd0);
        tick(1);
        check_eq("gto_answerSig", {31'd0, answerSig}, 32'd1);
        post(8'd33);
        check_eq("gto_segs", {resultSeg0, resultSeg1}, 32'h0000_B0B0);
        check_eq("gto_roundWin", {31'd0, roundWin}, 32'd1);
        tick(4);

        // Reset while in ANSWER.
        start_round("rma_start");
        gen_done(8'd4);
        @(negedge clk) Reset = 1'b1;
        @(negedge clk) Reset = 1'b0;
        check_eq("rma_segs", {resultSeg0, resultSeg1, resultSeg2, resultSeg3}, 32'hFFFF_FFFF);
        check_eq("rma_fault", {31'd0, fault}, 32'd0);
        gen_base = gen_cnt;
        ans_base = ans_cnt;
        post(8'd4);
        step(2);
        check_eq("rma_late_post_win", {31'd0, roundWin}, 32'd0);
        check_eq("rma_late_post_segs", {resultSeg0, resultSeg1, resultSeg2, resultSeg3}, 32'hFFFF_FFFF);
        tick(8);
        check_eq("rma_no_pulses", (gen_cnt - gen_base) + (ans_cnt - ans_base), 32'd0);
        start_round("rma_restart");

        step(2);
        check_eq("pulse_overlap", both_cnt, 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_fail);
        $finish;
    end

endmodule
